// File: rtl/mealy_overlapping.sv
// -----------------------------------------------------------------------------
// mealy_overlapping
//   Mealy serial detector for the fixed pattern 1011 on a 1-bit stream.
//   Matches may overlap: after a hit the search resumes from the trailing "1".
//   One bit is consumed per rising clock edge.
//
// Ports (positional order din, clk, reset, dout):
//   din          in   1  serial data bit, consumed at the rising edge of clk
//   clk          in   1  system clock
//   reset        in   1  asynchronous reset, active-low; clears the FSM at once
//   dout         out  1  match flag, combinational from (state, din); high
//                        while the current prefix plus din complete 1011
//   match_count  out  8  (MATCH_COUNT_EN only) number of matches seen since
//                        reset, wrapping 255 -> 0
//
// Build option:
//   MATCH_COUNT_EN  adds the 8-bit match_count output and its counter.
// -----------------------------------------------------------------------------
module mealy_overlapping (
  input  logic       din,
  input  logic       clk,
  input  logic       reset,
  output logic       dout
`ifdef MATCH_COUNT_EN
  ,
  output logic [7:0] match_count
`endif
);

  // Each state names the longest pattern prefix that the stream currently ends with.
  typedef enum logic [1:0] {
    S0 = 2'b00,  // nothing matched
    S1 = 2'b01,  // "1"
    S2 = 2'b10,  // "10"
    S3 = 2'b11   // "101"
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   match_s;

  // State register; reset returns to S0 without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and raw match decode.
  always_comb begin
    state_d = S0;
    match_s = 1'b0;
    case (state_q)
      S0: begin
        if (din) state_d = S1;
        else     state_d = S0;
      end
      S1: begin
        if (din) state_d = S1;   // "11" still ends in "1"
        else     state_d = S2;
      end
      S2: begin
        if (din) state_d = S3;
        else     state_d = S0;   // "100" keeps no usable prefix
      end
      S3: begin
        if (din) begin
          state_d = S1;          // trailing "1" of the hit starts the next one
          match_s = 1'b1;
        end else begin
          state_d = S2;          // "1010" still ends in "10"
        end
      end
      default: begin
        state_d = S0;
        match_s = 1'b0;
      end
    endcase
  end

  // Output gate: the flag must read 0 while reset is held, whatever din does.
  always_comb begin
    dout = 1'b0;
    if (reset) begin
      dout = match_s;
    end else begin
      dout = 1'b0;
    end
  end

`ifdef MATCH_COUNT_EN
  logic [7:0] count_q;
  logic [7:0] count_d;

  // Counter next value; natural 8-bit overflow gives the 255 -> 0 wrap.
  always_comb begin
    count_d = count_q;
    if (match_s) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Match counter register, cleared together with the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign match_count = count_q;
`endif

endmodule

// File: tb/tb_mealy_overlapping.sv
// -----------------------------------------------------------------------------
// tb_mealy_overlapping
//   Directed bench for the 1011 overlapping Mealy detector: a table of
//   {reset, din, expected dout} rows, a hand-written asynchronous reset pulse,
//   and a random stream checked against a shift-register reference.
// -----------------------------------------------------------------------------
module tb_mealy_overlapping;

  logic clk;
  logic reset;
  logic din;
  logic dout;
`ifdef MATCH_COUNT_EN
  logic [7:0] match_count;
`endif

  int n_cmp;
  int n_fail;

  // Reference: last three consumed bits and a match counter, cleared by reset.
  logic [2:0] hist;
  logic [7:0] ref_cnt;

  typedef struct {
    logic r;
    logic d;
    logic e;
  } vec_t;

  vec_t vecs[$];

  mealy_overlapping dut (
    .din         (din),
    .clk         (clk),
    .reset       (reset),
    .dout        (dout)
`ifdef MATCH_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time budget");
    $fatal(1);
  end

  function automatic logic ref_match(input logic r, input logic d);
    return r && ({hist, d} == 4'b1011);
  endfunction

  task automatic check_dout(input logic exp, input string name);
    n_cmp++;
    if (dout !== exp) begin
      n_fail++;
      $display("FAIL %s: dout=%b expected %b at t=%0t", name, dout, exp, $time);
    end
  endtask

  // Advance the reference as the DUT will at the coming rising edge.
  task automatic ref_update(input logic r, input logic d);
    if (r) begin
      if (ref_match(r, d)) ref_cnt = ref_cnt + 8'd1;
      hist = {hist[1:0], d};
    end else begin
      hist    = 3'b000;
      ref_cnt = 8'd0;
    end
  endtask

  // Drive one cycle: inputs at the falling edge, check, then let the rising edge consume them.
  task automatic step(input logic r, input logic d, input logic exp, input string name);
    @(negedge clk);
    reset = r;
    din   = d;
    #1;
    check_dout(exp, name);
    ref_update(r, d);
    @(posedge clk);
  endtask

`ifdef MATCH_COUNT_EN
  task automatic check_count(input logic [7:0] exp, input string name);
    @(negedge clk);
    n_cmp++;
    if (match_count !== exp) begin
      n_fail++;
      $display("FAIL %s: match_count=%0d expected %0d", name, match_count, exp);
    end
  endtask
`endif

  task automatic add(input logic r, input logic d, input logic e);
    vec_t v;
    v.r = r;
    v.d = d;
    v.e = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic d;
    logic e;
    n_cmp   = 0;
    n_fail  = 0;
    hist    = 3'b000;
    ref_cnt = 8'd0;
    reset   = 1'b0;
    din     = 1'b0;

    // Reset hold with din toggling, then 1011 -> hit on bit 4.
    add(1'b0, 1'b1, 1'b0); add(1'b0, 1'b0, 1'b0); add(1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b0, 1'b0); add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b1, 1'b1);
    // Overlap: 1011011 -> hits on bits 4 and 7.
    add(1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b0, 1'b0); add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b0); add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b1, 1'b1);
    // Near miss through S3 -> S2: 101011 -> hit on bit 6.
    add(1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b0, 1'b0); add(1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0); add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b1, 1'b1);
    // 10011 -> never.
    add(1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b0, 1'b0); add(1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b1, 1'b0);
    // Run of ones: 111011 -> hit on bit 6.
    add(1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0); add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b1, 1'b1);
    // Reach S3, then reset held with din=1: flag must stay low.
    add(1'b1, 1'b0, 1'b0); add(1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0);

    // Reset state before anything is consumed.
    #1;
    check_dout(1'b0, "reset_idle");
`ifdef MATCH_COUNT_EN
    check_count(8'd0, "reset_count");
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].d, vecs[i].e, $sformatf("vec%0d", i));
    end

    // Mid-sequence asynchronous reset: 101, pulse reset between edges, then 1 -> no hit.
    step(1'b1, 1'b1, 1'b0, "async_pre1");
    step(1'b1, 1'b0, 1'b0, "async_pre2");
    step(1'b1, 1'b1, 1'b0, "async_pre3");
    @(negedge clk);
    din = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    din = 1'b1;
    #1;
    check_dout(1'b0, "async_held");
    reset = 1'b1;
    #1;
    check_dout(1'b0, "async_released");
    ref_update(1'b0, 1'b0);
    ref_update(1'b1, 1'b1);
    @(posedge clk);
    step(1'b1, 1'b0, 1'b0, "async_post1");
    step(1'b1, 1'b1, 1'b0, "async_post2");
    step(1'b1, 1'b1, 1'b1, "async_post3");

    // Random stream against the shift-register reference.
    step(1'b0, 1'b0, 1'b0, "rand_reset");
    for (int i = 0; i < 40; i++) begin
      d = 1'($urandom_range(0, 1));
      e = ref_match(1'b1, d);
      step(1'b1, d, e, $sformatf("rand%0d", i));
    end
`ifdef MATCH_COUNT_EN
    check_count(ref_cnt, "rand_count");

    // Counter wrap: 1011 then 255 x 011 gives 256 hits -> back to 0.
    step(1'b0, 1'b0, 1'b0, "wrap_reset");
    step(1'b1, 1'b1, 1'b0, "wrap_a");
    step(1'b1, 1'b0, 1'b0, "wrap_b");
    step(1'b1, 1'b1, 1'b0, "wrap_c");
    step(1'b1, 1'b1, 1'b1, "wrap_d");
    for (int i = 0; i < 255; i++) begin
      step(1'b1, 1'b0, 1'b0, "wrap_0");
      step(1'b1, 1'b1, 1'b0, "wrap_1");
      step(1'b1, 1'b1, 1'b1, "wrap_hit");
      if (i == 253) check_count(8'd255, "count_255");
    end
    check_count(8'd0, "count_wrap");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
